// File: rtl/alu_cmd_driver_if.sv
// Host command/response channels and ALU drive/return signals of the ALU command driver.
// The driver attaches through the slave modport; host and ALU models attach through master.
interface alu_cmd_driver_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_opcode;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_err;
  logic        alu_start;
  logic [1:0]  alu_opcode;
  logic [7:0]  alu_operand_A;
  logic [7:0]  alu_operand_B;
  logic [15:0] alu_result;
  logic        alu_done;

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready, alu_result, alu_done,
    output cmd_ready, rsp_valid, rsp_result, rsp_err,
           alu_start, alu_opcode, alu_operand_A, alu_operand_B
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready, alu_result, alu_done,
    input  cmd_ready, rsp_valid, rsp_result, rsp_err,
           alu_start, alu_opcode, alu_operand_A, alu_operand_B
  );
endinterface

// File: rtl/alu_cmd_driver.sv
// Initiator-side sequencer for the 8-bit ALU: takes one host command at a time,
// pulses the ALU, waits fixed latency (ADD/SUB) or done/timeout (MUL/DIV), returns the result.
//
// state     | meaning
// IDLE      | ready for a host command
// ISSUE     | one-cycle start pulse to the ALU
// WAIT_FIX  | counting fixed ADD/SUB latency
// WAIT_DONE | waiting for alu_done or timeout
// RESP      | response held until the host accepts it
module alu_cmd_driver #(
  parameter int unsigned FIX_LAT = 2,
  parameter int unsigned TIMEOUT = 64,
  parameter bit          DIV_EN  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_cmd_driver_if.slave  bus,
  output logic             busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_FIX  = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_RESP      = 3'd4;

  localparam logic [7:0] FIX_TC = 8'(FIX_LAT - 1);
  localparam logic [7:0] TO_TC  = 8'(TIMEOUT - 1);

  logic [2:0] state;
  logic [7:0] cnt;
  logic       done_seen;
  logic       reject_op;
  logic [7:0] cnt_inc;

  assign reject_op = (bus.cmd_opcode == 2'b11) && !DIV_EN;
  assign cnt_inc   = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

  // Handshake and start outputs decode straight from state so reset clears them at once.
  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.alu_start = (state == S_ISSUE);
  assign busy          = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      cnt               <= 8'd0;
      done_seen         <= 1'b0;
      bus.alu_opcode    <= 2'd0;
      bus.alu_operand_A <= 8'd0;
      bus.alu_operand_B <= 8'd0;
      bus.rsp_result    <= 16'd0;
      bus.rsp_err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            bus.alu_opcode    <= bus.cmd_opcode;
            bus.alu_operand_A <= bus.cmd_a;
            bus.alu_operand_B <= bus.cmd_b;
            bus.rsp_result    <= 16'd0;
            bus.rsp_err       <= reject_op;
            state             <= reject_op ? S_RESP : S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt       <= 8'd0;
          // A done already present alongside the start pulse is kept, not filtered.
          done_seen <= bus.alu_done;
          state     <= bus.alu_opcode[1] ? S_WAIT_DONE : S_WAIT_FIX;
        end
        S_WAIT_FIX: begin
          if (cnt == FIX_TC) begin
            bus.rsp_result <= bus.alu_result;
            bus.rsp_err    <= 1'b0;
            state          <= S_RESP;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_WAIT_DONE: begin
          if (bus.alu_done || done_seen) begin
            bus.rsp_result <= bus.alu_result;
            bus.rsp_err    <= 1'b0;
            state          <= S_RESP;
          end else if (cnt == TO_TC) begin
            bus.rsp_result <= 16'd0;
            bus.rsp_err    <= 1'b1;
            state          <= S_RESP;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver: a transaction-level model predicts every cycle's
// outputs, and literal expectations per scenario pin that model.
module tb_alu_cmd_driver;
  localparam int FIX_LAT = 2;
  localparam int TIMEOUT = 64;
  localparam bit DIV_EN  = 1'b0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  alu_cmd_driver_if bus();

  alu_cmd_driver #(.FIX_LAT(FIX_LAT), .TIMEOUT(TIMEOUT), .DIV_EN(DIV_EN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [15:0] alu_fn(input logic [1:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      2'd0:    return 16'(a) + 16'(b);
      2'd1:    return 16'(a) - 16'(b);
      2'd2:    return 16'(a) * 16'(b);
      default: return (b != 8'd0) ? 16'(a / b) : 16'hFFFF;
    endcase
  endfunction

  // Transaction model: one outstanding operation with its predicted start and response cycles.
  bit          pending  = 1'b0;
  bit          m_issued = 1'b0;
  int          start_cyc, resp_cyc;
  logic [15:0] m_res = 16'd0;
  bit          m_err = 1'b0;
  logic [1:0]  m_op  = 2'd0;
  logic [7:0]  m_a   = 8'd0;
  logic [7:0]  m_b   = 8'd0;

  // ALU behaviour: done_delay < 0 means the ALU never raises done.
  int done_delay    = -1;
  int alu_start_cyc = 0;
  bit started       = 1'b0;
  int start_count   = 0;

  always @(negedge clk) begin
    bit exp_valid;
    cyc++;
    if (!rst_n) begin
      pending = 1'b0;
      m_op = 2'd0; m_a = 8'd0; m_b = 8'd0;
      started = 1'b0;
      bus.alu_done = 1'b0;
      chk("rst_cmd_ready", bus.cmd_ready, 1);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_alu_start", bus.alu_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_result", bus.rsp_result, 0);
      chk("rst_rsp_err", bus.rsp_err, 0);
      chk("rst_operands", {bus.alu_opcode, bus.alu_operand_A, bus.alu_operand_B}, 0);
    end else begin
      exp_valid = pending && (cyc >= resp_cyc);
      chk("cmd_ready", bus.cmd_ready, !pending);
      chk("busy", busy, pending);
      chk("alu_start", bus.alu_start, pending && m_issued && (cyc == start_cyc));
      chk("rsp_valid", bus.rsp_valid, exp_valid);
      if (exp_valid) begin
        chk("rsp_result", bus.rsp_result, m_res);
        chk("rsp_err", bus.rsp_err, m_err);
      end
      chk("alu_drive", {bus.alu_opcode, bus.alu_operand_A, bus.alu_operand_B}, {m_op, m_a, m_b});

      if (bus.alu_start === 1'b1) begin
        alu_start_cyc  = cyc;
        started        = 1'b1;
        start_count++;
        bus.alu_result = alu_fn(bus.alu_opcode, bus.alu_operand_A, bus.alu_operand_B);
      end
      bus.alu_done = started && (done_delay >= 0) && (cyc == alu_start_cyc + done_delay);

      if (exp_valid && bus.rsp_ready) begin
        pending = 1'b0;
      end else if (!pending && bus.cmd_valid) begin
        pending = 1'b1;
        m_op = bus.cmd_opcode; m_a = bus.cmd_a; m_b = bus.cmd_b;
        if (m_op == 2'd3 && !DIV_EN) begin
          m_issued = 1'b0; resp_cyc = cyc + 1; m_res = 16'd0; m_err = 1'b1;
        end else begin
          m_issued  = 1'b1;
          start_cyc = cyc + 1;
          if (!m_op[1]) begin
            resp_cyc = start_cyc + FIX_LAT + 1; m_res = alu_fn(m_op, m_a, m_b); m_err = 1'b0;
          end else if (done_delay >= 1 && done_delay <= TIMEOUT) begin
            resp_cyc = start_cyc + done_delay + 1; m_res = alu_fn(m_op, m_a, m_b); m_err = 1'b0;
          end else begin
            resp_cyc = start_cyc + TIMEOUT + 1; m_res = 16'd0; m_err = 1'b1;
          end
        end
      end
    end
  end

  // Returns in the cycle after acceptance (the ISSUE cycle when the op is forwarded).
  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    bit got = 1'b0;
    @(posedge clk); #1;
    bus.cmd_opcode = op; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (bus.cmd_ready) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("send_accept_timeout", got, 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Cycles from the send return point until rsp_valid; returns with rsp_valid observed.
  task automatic wait_rsp(output int lat, output logic [15:0] res, output logic err);
    lat = -1; res = 16'hDEAD; err = 1'bx;
    for (int i = 0; i < 300; i++) begin
      if (bus.rsp_valid) begin lat = i; res = bus.rsp_result; err = bus.rsp_err; break; end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int          lat, sc;
    logic [15:0] res;
    logic        err;
    bus.cmd_valid = 1'b0; bus.cmd_opcode = 2'd0; bus.cmd_a = 8'd0; bus.cmd_b = 8'd0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd_ready", bus.cmd_ready, 1);
    chk("reset_rsp_result", bus.rsp_result, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;

    // ADD 15+10: single start pulse, response FIX_LAT+1 cycles after ISSUE
    sc = start_count;
    send(2'd0, 8'd15, 8'd10);
    wait_rsp(lat, res, err);
    chk("add_lat", lat, 3);
    chk("add_result", res, 25);
    chk("add_err", err, 0);
    chk("add_one_pulse", start_count - sc, 1);

    send(2'd1, 8'd20, 8'd5);
    wait_rsp(lat, res, err);
    chk("sub_result", res, 15);
    chk("sub_err", err, 0);

    // Back-to-back ADD then SUB with cmd_valid held throughout
    @(posedge clk); #1;
    bus.cmd_opcode = 2'd0; bus.cmd_a = 8'd3; bus.cmd_b = 8'd4; bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_opcode = 2'd1; bus.cmd_a = 8'd9; bus.cmd_b = 8'd4;
    chk("b2b_ready_low", bus.cmd_ready, 0);
    wait_rsp(lat, res, err);
    chk("b2b_add_result", res, 7);
    for (int i = 0; i < 10; i++) begin
      if (bus.cmd_ready) begin
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    chk("b2b_second_accepted", bus.cmd_valid, 0);
    wait_rsp(lat, res, err);
    chk("b2b_sub_lat", lat, 3);
    chk("b2b_sub_result", res, 5);

    // MUL 7*3, ALU done 9 cycles after start
    done_delay = 9;
    send(2'd2, 8'd7, 8'd3);
    wait_rsp(lat, res, err);
    chk("mul_lat", lat, 10);
    chk("mul_result", res, 21);
    chk("mul_err", err, 0);

    // MUL with no done: timeout, then a normal ADD
    done_delay = -1;
    send(2'd2, 8'd7, 8'd3);
    wait_rsp(lat, res, err);
    chk("tmo_lat", lat, TIMEOUT + 1);
    chk("tmo_result", res, 0);
    chk("tmo_err", err, 1);
    send(2'd0, 8'd100, 8'd200);
    wait_rsp(lat, res, err);
    chk("post_tmo_result", res, 300);
    chk("post_tmo_err", err, 0);

    // DIV rejected locally: no start pulse
    sc = start_count;
    send(2'd3, 8'd8, 8'd2);
    wait_rsp(lat, res, err);
    chk("div_lat", lat, 0);
    chk("div_result", res, 0);
    chk("div_err", err, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("div_no_start", start_count - sc, 0);

    // Response back-pressure for 5 cycles
    bus.rsp_ready = 1'b0;
    send(2'd0, 8'hFF, 8'hFF);
    wait_rsp(lat, res, err);
    chk("bp_first_result", res, 510);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid_held", bus.rsp_valid, 1);
      chk("bp_result_held", bus.rsp_result, 510);
      chk("bp_ready_low", bus.cmd_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_released", bus.rsp_valid, 0);

    // Reset pulse in WAIT_DONE, then ADD 1+1
    done_delay = -1;
    send(2'd2, 8'd5, 8'd5);
    repeat (4) @(posedge clk);
    #2;
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_start", bus.alu_start, 0);
    chk("rst_mid_valid", bus.rsp_valid, 0);
    chk("rst_mid_ready", bus.cmd_ready, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_opA", bus.alu_operand_A, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(2'd0, 8'd1, 8'd1);
    wait_rsp(lat, res, err);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_result", res, 2);
    chk("post_rst_err", err, 0);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, limit 100000", $time);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
- Initiator-side sequencer for the 8-bit ALU.
- Accepts operation commands from a host over a valid/ready channel and drives the ALU's start/opcode/operand interface.
- Waits for the ALU's result, using fixed latency for ADD/SUB and the done handshake for MUL/DIV, then returns the result over a valid/ready response channel.
- Sits between the system controller and the ALU top level; replaces hand-sequenced start pulses.

Parameters:
- FIX_LAT, 2, cycles after the start pulse at which the ADD/SUB result is sampled (legal range 1..15).
- TIMEOUT, 64, max cycles waiting for alu_done on MUL/DIV before aborting (legal range 2..255).
- DIV_EN, 0, 1 = opcode 11 is forwarded to the ALU; 0 = opcode 11 is rejected locally.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  driver can accept a command
- cmd_opcode  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
- cmd_a  in  8  operand A
- cmd_b  in  8  operand B
- rsp_valid  out  1  response valid
- rsp_ready  in  1  host accepts response
- rsp_result  out  16  captured ALU result (0 on error)
- rsp_err  out  1  1 = timeout or rejected opcode
- alu_start  out  1  one-cycle start pulse to ALU
- alu_opcode  out  2  opcode to ALU
- alu_operand_A  out  8  operand A to ALU
- alu_operand_B  out  8  operand B to ALU
- alu_result  in  16  ALU result
- alu_done  in  1  ALU completion (MUL/DIV)
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync-released internally by flops on clk): state IDLE; cmd_ready=1, rsp_valid=0, rsp_result=0, rsp_err=0, alu_start=0, alu_opcode=0, alu_operand_A/B=0, busy=0, counters=0.
- States: IDLE, ISSUE, WAIT_FIX, WAIT_DONE, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch opcode/a/b into the alu_* registers.
  - Opcode 11 with DIV_EN=0: go to RESP with rsp_err=1, rsp_result=0; no alu_start.
  - Otherwise go to ISSUE.
- ISSUE: alu_start=1 for exactly this one cycle.
  - Opcode 00/01: go to WAIT_FIX.
  - Opcode 10/11: go to WAIT_DONE.
  - Wait counter cleared.
- WAIT_FIX: count up; when count==FIX_LAT-1, capture alu_result into rsp_result, rsp_err=0, go to RESP. Total: result sampled FIX_LAT cycles after the start cycle.
- WAIT_DONE:
  - alu_done sampled high: capture alu_result, rsp_err=0, go to RESP.
  - Else when count reaches TIMEOUT-1: rsp_result=0, rsp_err=1, go to RESP.
  - alu_done asserting on the same cycle as the timeout: done wins.
  - alu_done high during ISSUE or the first WAIT_DONE cycle is honoured (stale-done is not filtered).
- RESP:
  - rsp_valid=1; rsp_result/rsp_err held stable until rsp_valid&rsp_ready.
  - Then go to IDLE.
  - cmd_ready is 0 in RESP; no command/response overlap, so at most one outstanding operation.
- alu_opcode/alu_operand_A/alu_operand_B held stable from ISSUE until leaving WAIT_FIX/WAIT_DONE; they keep their last values in IDLE.
- cmd_ready=0 in every state except IDLE.
- Back-to-back throughput (rsp_ready tied 1):
  - ADD/SUB: one command every FIX_LAT+3 cycles.
  - MUL: ALU latency + 3.
- alu_done seen in IDLE/RESP/WAIT_FIX is ignored.
- rst_n asserted mid-operation: immediate return to the reset values; the pending command and response are discarded. alu_start drops asynchronously.
- Counters are 8 bits wide and saturate; never wrap.

Test Plan:
- ADD, cmd_a=15, cmd_b=10, opcode 00, rsp_ready=1:
  - alu_start is a single pulse.
  - rsp_valid is asserted FIX_LAT+1 cycles after ISSUE with rsp_result=25, rsp_err=0.
- SUB, cmd_a=20, cmd_b=5: rsp_result=15, rsp_err=0.
- Back-to-back ADD then SUB with cmd_valid held: cmd_ready is low during the first op; the second is accepted only after the first response handshake.
- MUL, cmd_a=7, cmd_b=3, opcode 10, ALU raises done after 9 cycles:
  - rsp_result=21, rsp_err=0.
  - Operands remain stable through WAIT_DONE.
- MUL with the ALU model never asserting done:
  - rsp_valid is asserted after TIMEOUT cycles in WAIT_DONE with rsp_err=1, rsp_result=0.
  - The next command is then accepted normally.
- Opcode 11 with DIV_EN=0: no alu_start ever; response has rsp_err=1, rsp_result=0.
- rsp_ready held low for 5 cycles:
  - rsp_valid and rsp_result stay constant; cmd_ready stays 0.
  - Handshake completes when rsp_ready rises.
- rst_n pulsed low during WAIT_DONE:
  - All outputs return to their reset values immediately.
  - A subsequent ADD 1+1 returns 2.
